// File: rtl/zbt_frame_arbiter.sv
//----------------------------------------------------------------------------
// zbt_frame_arbiter
//
// Single-port arbiter and sequencer for the pipelined ZBT frame memory.
// Each 36-bit word holds two 18-bit YCrCb pixels.
//
// Three requesters share the memory under a fixed priority:
//   VGA display reads  >  NTSC capture writes  >  processor read/write.
// Each requester has a one-deep pending register. At most one request is
// granted per cycle. The grant is registered onto mem_addr/mem_we and is
// tracked through a latency pipeline. For a write, the pipeline drives
// mem_wdata LAT cycles after the address cycle. For a read, it steers
// mem_rdata back to the requester.
//
// Two frame banks are used in ping-pong fashion. VGA scans display_bank and
// NTSC fills ~display_bank. A frame_flag requests a bank swap. The swap waits
// until no NTSC write is still in flight, so a captured frame is never split
// across banks.
//
// Ports:
//   clock, reset           system clock; synchronous active-low reset
//   frame_flag             NTSC write bank complete (one-cycle pulse)
//   vga_flag/hcount/vcount VGA read request; vga_pixel/done_vga return
//   ntsc_flag/addr/data    NTSC write request; done_ntsc on acceptance
//   proc_flag/we/bank/addr/wdata
//                          processor request; proc_rdata/done_proc return
//   mem_addr/mem_we/mem_wdata/mem_rdata
//                          ZBT memory pins
//   display_bank           bank currently scanned by VGA
//   overflow               sticky lost-request flags {proc, ntsc, vga}
//----------------------------------------------------------------------------
module zbt_frame_arbiter #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 36,
    parameter int LAT    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              frame_flag,
    input  logic              vga_flag,
    input  logic [9:0]        vga_hcount,
    input  logic [9:0]        vga_vcount,
    output logic [DATA_W-1:0] vga_pixel,
    output logic              done_vga,
    input  logic              ntsc_flag,
    input  logic [17:0]       ntsc_addr,
    input  logic [DATA_W-1:0] ntsc_data,
    output logic              done_ntsc,
    input  logic              proc_flag,
    input  logic              proc_we,
    input  logic              proc_bank,
    input  logic [17:0]       proc_addr,
    input  logic [DATA_W-1:0] proc_wdata,
    output logic [DATA_W-1:0] proc_rdata,
    output logic              done_proc,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              display_bank,
    output logic [2:0]        overflow
);

    localparam logic [1:0] ID_VGA  = 2'd1;
    localparam logic [1:0] ID_NTSC = 2'd2;
    localparam logic [1:0] ID_PROC = 2'd3;

    // One in-flight memory access
    typedef struct packed {
        logic              valid;
        logic [1:0]        id;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } pipe_t;

    // Pending request registers
    logic              vga_pend_r;
    logic [8:0]        vga_row_r;
    logic [8:0]        vga_col_r;
    logic              ntsc_pend_r;
    logic [17:0]       ntsc_addr_r;
    logic [DATA_W-1:0] ntsc_data_r;
    logic              proc_pend_r;
    logic              proc_we_r;
    logic              proc_bank_r;
    logic [17:0]       proc_addr_r;
    logic [DATA_W-1:0] proc_wdata_r;

    // Memory side and latency pipeline
    // pipe_r[0] is the address cycle; pipe_r[LAT] is the data cycle.
    logic [ADDR_W-1:0] mem_addr_r;
    logic              mem_we_r;
    logic [DATA_W-1:0] mem_wdata_r;
    pipe_t             pipe_r [0:LAT];

    // Return data and status
    logic [DATA_W-1:0] vga_pixel_r;
    logic [DATA_W-1:0] proc_rdata_r;
    logic              done_vga_r;
    logic              done_ntsc_r;
    logic              done_proc_r;
    logic              display_bank_r;
    logic              swap_pending_r;
    logic [2:0]        overflow_r;

    // Combinational grant and pipeline status
    logic              gnt_vga_s;
    logic              gnt_ntsc_s;
    logic              gnt_proc_s;
    pipe_t             gnt_entry_s;
    logic [ADDR_W-1:0] gnt_addr_s;
    logic              ntsc_in_pipe_s;
    pipe_t             last_s;
    pipe_t             pre_last_s;
    logic              vga_rd_done_s;
    logic              proc_rd_done_s;

    // The LSB of hcount selects the pixel within a word. Bit 9 of vcount is
    // outside the 512-line bank. Neither bit takes part in the address.
    logic unused_s;
    assign unused_s = ^{vga_hcount[0], vga_vcount[9]};

    // Fixed priority. NTSC is held off while a bank swap is pending, so a
    // swap cannot split a frame.
    assign gnt_vga_s  = vga_pend_r;
    assign gnt_ntsc_s = ntsc_pend_r & ~vga_pend_r & ~swap_pending_r;
    assign gnt_proc_s = proc_pend_r & ~vga_pend_r & ~gnt_ntsc_s;

    assign last_s         = pipe_r[LAT];
    assign pre_last_s     = pipe_r[LAT-1];
    assign vga_rd_done_s  = last_s.valid & ~last_s.we & (last_s.id == ID_VGA);
    assign proc_rd_done_s = last_s.valid & ~last_s.we & (last_s.id == ID_PROC);

    // Build the pipeline entry and memory address for this cycle's grant
    always_comb begin
        gnt_entry_s = '0;
        gnt_addr_s  = mem_addr_r;
        if (gnt_vga_s) begin
            gnt_entry_s.valid = 1'b1;
            gnt_entry_s.id    = ID_VGA;
            gnt_entry_s.we    = 1'b0;
            gnt_addr_s        = ADDR_W'({display_bank_r, vga_row_r, vga_col_r});
        end else if (gnt_ntsc_s) begin
            gnt_entry_s.valid = 1'b1;
            gnt_entry_s.id    = ID_NTSC;
            gnt_entry_s.we    = 1'b1;
            gnt_entry_s.wdata = ntsc_data_r;
            gnt_addr_s        = ADDR_W'({~display_bank_r, ntsc_addr_r});
        end else if (gnt_proc_s) begin
            gnt_entry_s.valid = 1'b1;
            gnt_entry_s.id    = ID_PROC;
            gnt_entry_s.we    = proc_we_r;
            gnt_entry_s.wdata = proc_wdata_r;
            gnt_addr_s        = ADDR_W'({proc_bank_r, proc_addr_r});
        end else begin
            gnt_entry_s = '0;
            gnt_addr_s  = mem_addr_r;
        end
    end

    // Detect any NTSC write still travelling through the latency pipeline
    always_comb begin
        ntsc_in_pipe_s = 1'b0;
        for (int i = 0; i <= LAT; i++) begin
            ntsc_in_pipe_s = ntsc_in_pipe_s |
                             (pipe_r[i].valid & (pipe_r[i].id == ID_NTSC));
        end
    end

    // VGA pending register: a flag fills it when it is empty or being granted
    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_pend_r <= 1'b0;
            vga_row_r  <= 9'd0;
            vga_col_r  <= 9'd0;
        end else if (vga_flag && (!vga_pend_r || gnt_vga_s)) begin
            vga_pend_r <= 1'b1;
            vga_row_r  <= vga_vcount[8:0];
            vga_col_r  <= vga_hcount[9:1];
        end else if (gnt_vga_s) begin
            vga_pend_r <= 1'b0;
        end
    end

    // NTSC pending register: latches while a swap is pending and waits there
    always_ff @(posedge clock) begin
        if (!reset) begin
            ntsc_pend_r <= 1'b0;
            ntsc_addr_r <= 18'd0;
            ntsc_data_r <= '0;
        end else if (ntsc_flag && (!ntsc_pend_r || gnt_ntsc_s)) begin
            ntsc_pend_r <= 1'b1;
            ntsc_addr_r <= ntsc_addr;
            ntsc_data_r <= ntsc_data;
        end else if (gnt_ntsc_s) begin
            ntsc_pend_r <= 1'b0;
        end
    end

    // Processor pending register
    always_ff @(posedge clock) begin
        if (!reset) begin
            proc_pend_r  <= 1'b0;
            proc_we_r    <= 1'b0;
            proc_bank_r  <= 1'b0;
            proc_addr_r  <= 18'd0;
            proc_wdata_r <= '0;
        end else if (proc_flag && (!proc_pend_r || gnt_proc_s)) begin
            proc_pend_r  <= 1'b1;
            proc_we_r    <= proc_we;
            proc_bank_r  <= proc_bank;
            proc_addr_r  <= proc_addr;
            proc_wdata_r <= proc_wdata;
        end else if (gnt_proc_s) begin
            proc_pend_r  <= 1'b0;
        end
    end

    // Sticky overflow: a flag hitting an occupied pending register is lost
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow_r <= 3'b000;
        end else begin
            overflow_r <= overflow_r |
                          {proc_flag & proc_pend_r & ~gnt_proc_s,
                           ntsc_flag & ntsc_pend_r & ~gnt_ntsc_s,
                           vga_flag  & vga_pend_r  & ~gnt_vga_s};
        end
    end

    // Address cycle, latency pipeline and write data launch
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_addr_r  <= '0;
            mem_we_r    <= 1'b0;
            mem_wdata_r <= '0;
            for (int i = 0; i <= LAT; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            mem_we_r <= gnt_entry_s.valid & gnt_entry_s.we;
            if (gnt_entry_s.valid) begin
                mem_addr_r <= gnt_addr_s;
            end
            pipe_r[0] <= gnt_entry_s;
            for (int i = 1; i <= LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
            // Load mem_wdata as the write enters the data cycle
            if (pre_last_s.valid && pre_last_s.we) begin
                mem_wdata_r <= pre_last_s.wdata;
            end
        end
    end

    // Read data return and completion pulses
    always_ff @(posedge clock) begin
        if (!reset) begin
            vga_pixel_r  <= '0;
            proc_rdata_r <= '0;
            done_vga_r   <= 1'b0;
            done_ntsc_r  <= 1'b0;
            done_proc_r  <= 1'b0;
        end else begin
            done_vga_r  <= vga_rd_done_s;
            done_ntsc_r <= gnt_ntsc_s;
            done_proc_r <= proc_rd_done_s | (gnt_proc_s & proc_we_r);
            if (vga_rd_done_s) begin
                vga_pixel_r <= mem_rdata;
            end
            if (proc_rd_done_s) begin
                proc_rdata_r <= mem_rdata;
            end
        end
    end

    // Bank swap: toggle once the pipeline holds no NTSC write. Any
    // frame_flag seen while a swap is pending merges into that swap.
    always_ff @(posedge clock) begin
        if (!reset) begin
            display_bank_r <= 1'b0;
            swap_pending_r <= 1'b0;
        end else if (swap_pending_r && !ntsc_in_pipe_s) begin
            display_bank_r <= ~display_bank_r;
            swap_pending_r <= 1'b0;
        end else if (frame_flag) begin
            swap_pending_r <= 1'b1;
        end
    end

    assign vga_pixel    = vga_pixel_r;
    assign done_vga     = done_vga_r;
    assign done_ntsc    = done_ntsc_r;
    assign proc_rdata   = proc_rdata_r;
    assign done_proc    = done_proc_r;
    assign mem_addr     = mem_addr_r;
    assign mem_we       = mem_we_r;
    assign mem_wdata    = mem_wdata_r;
    assign display_bank = display_bank_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_zbt_frame_arbiter.sv
//----------------------------------------------------------------------------
// Testbench for zbt_frame_arbiter.
// A behavioural ZBT memory answers the DUT's bus with LAT cycles of latency.
// Expected read data and expected memory writes are queued when requests are
// issued. They are compared when the DUT completes each request.
//----------------------------------------------------------------------------
module tb_zbt_frame_arbiter;

    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        frame_flag = 1'b0;
    logic        vga_flag = 1'b0;
    logic [9:0]  vga_hcount = 10'd0;
    logic [9:0]  vga_vcount = 10'd0;
    logic [35:0] vga_pixel;
    logic        done_vga;
    logic        ntsc_flag = 1'b0;
    logic [17:0] ntsc_addr = 18'd0;
    logic [35:0] ntsc_data = 36'd0;
    logic        done_ntsc;
    logic        proc_flag = 1'b0;
    logic        proc_we = 1'b0;
    logic        proc_bank = 1'b0;
    logic [17:0] proc_addr = 18'd0;
    logic [35:0] proc_wdata = 36'd0;
    logic [35:0] proc_rdata;
    logic        done_proc;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [35:0] mem_wdata;
    logic [35:0] mem_rdata = 36'd0;
    logic        display_bank;
    logic [2:0]  overflow;

    zbt_frame_arbiter #(.ADDR_W(19), .DATA_W(36), .LAT(LAT)) dut (
        .clock(clock), .reset(reset), .frame_flag(frame_flag),
        .vga_flag(vga_flag), .vga_hcount(vga_hcount), .vga_vcount(vga_vcount),
        .vga_pixel(vga_pixel), .done_vga(done_vga),
        .ntsc_flag(ntsc_flag), .ntsc_addr(ntsc_addr), .ntsc_data(ntsc_data),
        .done_ntsc(done_ntsc),
        .proc_flag(proc_flag), .proc_we(proc_we), .proc_bank(proc_bank),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_rdata(proc_rdata), .done_proc(done_proc),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .display_bank(display_bank), .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          kind;      // 0 = VGA, 1 = NTSC, 2 = PROC
        logic        we;
        logic        bank;
        logic [9:0]  h;
        logic [9:0]  v;
        logic [17:0] addr;
        logic [35:0] data;
        logic [18:0] exp_addr;
    } vec_t;

    typedef struct { logic [18:0] a; logic [35:0] d; } wr_t;
    typedef struct { logic we; logic [35:0] d; } pr_t;

    int n_vec = 0;
    int n_err = 0;
    int ntsc_cnt = 0;

    logic [35:0] vga_q [$];
    pr_t         proc_q [$];
    wr_t         wr_q [$];
    logic [35:0] exp_mem [int];
    logic [35:0] mem_arr [int];

    logic [18:0] dl_addr [0:LAT];
    logic        dl_we [0:LAT];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [35:0] pat(input logic [18:0] a);
        return {a[16:0], a} ^ 36'h5A5A5A5A5;
    endfunction

    function automatic logic [35:0] exp_read(input logic [18:0] a);
        if (exp_mem.exists(int'(a))) return exp_mem[int'(a)];
        return pat(a);
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // Memory model plus completion monitor, evaluated mid-cycle
    always @(negedge clock) begin
        for (int i = LAT; i > 0; i--) begin
            dl_addr[i] = dl_addr[i-1];
            dl_we[i]   = dl_we[i-1];
        end
        dl_addr[0] = mem_addr;
        dl_we[0]   = mem_we && reset;
        if (dl_we[LAT]) begin
            if (wr_q.size() == 0) begin
                check("unexpected_mem_write", {45'd0, dl_addr[LAT]}, 64'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                check("mem_write_addr", {45'd0, dl_addr[LAT]}, {45'd0, w.a});
                check("mem_wdata", {28'd0, mem_wdata}, {28'd0, w.d});
            end
            mem_arr[int'(dl_addr[LAT])] = mem_wdata;
        end else if (mem_arr.exists(int'(dl_addr[LAT]))) begin
            mem_rdata = mem_arr[int'(dl_addr[LAT])];
        end else begin
            mem_rdata = pat(dl_addr[LAT]);
        end

        if (reset) begin
            if (done_vga) begin
                if (vga_q.size() == 0) check("unexpected_done_vga", 64'd1, 64'd0);
                else check("vga_pixel", {28'd0, vga_pixel}, {28'd0, vga_q.pop_front()});
            end
            if (done_proc) begin
                if (proc_q.size() == 0) begin
                    check("unexpected_done_proc", 64'd1, 64'd0);
                end else begin
                    pr_t p;
                    p = proc_q.pop_front();
                    if (!p.we) check("proc_rdata", {28'd0, proc_rdata}, {28'd0, p.d});
                end
            end
            if (done_ntsc) begin
                if (ntsc_cnt == 0) check("unexpected_done_ntsc", 64'd1, 64'd0);
                else ntsc_cnt--;
            end
        end
    end

    task automatic drive_vga(input logic [9:0] h, input logic [9:0] v, input logic [18:0] a);
        vga_flag = 1'b1; vga_hcount = h; vga_vcount = v;
        vga_q.push_back(exp_read(a));
    endtask

    task automatic drive_ntsc(input logic [17:0] ad, input logic [35:0] d, input logic [18:0] a);
        wr_t w;
        ntsc_flag = 1'b1; ntsc_addr = ad; ntsc_data = d;
        w.a = a; w.d = d;
        wr_q.push_back(w);
        exp_mem[int'(a)] = d;
        ntsc_cnt++;
    endtask

    task automatic drive_proc(input logic we, input logic bk, input logic [17:0] ad,
                              input logic [35:0] d, input logic [18:0] a);
        pr_t p;
        wr_t w;
        proc_flag = 1'b1; proc_we = we; proc_bank = bk; proc_addr = ad; proc_wdata = d;
        p.we = we;
        p.d  = we ? 36'd0 : exp_read(a);
        proc_q.push_back(p);
        if (we) begin
            w.a = a; w.d = d;
            wr_q.push_back(w);
            exp_mem[int'(a)] = d;
        end
    endtask

    task automatic clear_flags;
        vga_flag = 1'b0; ntsc_flag = 1'b0; proc_flag = 1'b0; frame_flag = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vga_pixel"},  {28'd0, vga_pixel},  64'd0);
        check({tag, "_proc_rdata"}, {28'd0, proc_rdata}, 64'd0);
        check({tag, "_mem_wdata"},  {28'd0, mem_wdata},  64'd0);
        check({tag, "_ctl"}, {37'd0, mem_addr, mem_we, done_vga, done_ntsc, done_proc,
                              display_bank, overflow}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vtab [9];
        int done_at;
        logic dn;

        for (int i = 0; i <= LAT; i++) begin
            dl_addr[i] = 19'd0;
            dl_we[i]   = 1'b0;
        end
        mem_arr[32'h00A06] = 36'h123456789;
        exp_mem[32'h00A06] = 36'h123456789;

        //           kind we    bank  h        v        addr       data            exp_addr
        vtab[0] = '{0, 1'b0, 1'b0, 10'd13,  10'd5,   18'h00000, 36'h000000000, 19'h00A06};
        vtab[1] = '{0, 1'b0, 1'b0, 10'd639, 10'd479, 18'h00000, 36'h000000000, 19'h3BF3F};
        vtab[2] = '{1, 1'b1, 1'b0, 10'd0,   10'd0,   18'h00010, 36'h0DEADBEEF, 19'h40010};
        vtab[3] = '{2, 1'b1, 1'b0, 10'd0,   10'd0,   18'h00123, 36'hABCDE0123, 19'h00123};
        vtab[4] = '{2, 1'b0, 1'b0, 10'd0,   10'd0,   18'h00123, 36'h000000000, 19'h00123};
        vtab[5] = '{2, 1'b0, 1'b1, 10'd0,   10'd0,   18'h3FFFF, 36'h000000000, 19'h7FFFF};
        vtab[6] = '{1, 1'b1, 1'b0, 10'd0,   10'd0,   18'h3FFFF, 36'hFFFFFFFFF, 19'h7FFFF};
        vtab[7] = '{2, 1'b0, 1'b1, 10'd0,   10'd0,   18'h3FFFF, 36'h000000000, 19'h7FFFF};
        vtab[8] = '{0, 1'b0, 1'b0, 10'd1,   10'd0,   18'h00000, 36'h000000000, 19'h00000};

        // Reset held for 3 cycles with every flag asserted
        reset = 1'b0;
        vga_flag = 1'b1; ntsc_flag = 1'b1; proc_flag = 1'b1; proc_we = 1'b1; frame_flag = 1'b1;
        ntsc_data = 36'h111111111; proc_wdata = 36'h222222222; vga_hcount = 10'd7;
        for (int c = 0; c < 3; c++) begin
            tick;
            check_idle_outputs("reset");
        end
        reset = 1'b1;
        clear_flags;
        proc_we = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick;
            check("post_reset_idle", {59'd0, mem_we, done_vga, done_ntsc, done_proc, display_bank}, 64'd0);
        end

        // Single-requester vectors: address, direction and completion latency
        for (int i = 0; i < 9; i++) begin
            case (vtab[i].kind)
                0:       drive_vga(vtab[i].h, vtab[i].v, vtab[i].exp_addr);
                1:       drive_ntsc(vtab[i].addr, vtab[i].data, vtab[i].exp_addr);
                default: drive_proc(vtab[i].we, vtab[i].bank, vtab[i].addr, vtab[i].data,
                                    vtab[i].exp_addr);
            endcase
            tick;
            clear_flags;
            done_at = 0;
            for (int k = 1; k <= LAT + 4; k++) begin
                tick;
                if (k == 1) begin
                    check($sformatf("vec%0d_mem_addr", i), {45'd0, mem_addr}, {45'd0, vtab[i].exp_addr});
                    check($sformatf("vec%0d_mem_we", i), {63'd0, mem_we},
                          {63'd0, (vtab[i].kind == 1) || (vtab[i].kind == 2 && vtab[i].we)});
                end
                case (vtab[i].kind)
                    0:       dn = done_vga;
                    1:       dn = done_ntsc;
                    default: dn = done_proc;
                endcase
                if (done_at == 0 && dn) done_at = k;
            end
            check($sformatf("vec%0d_done_latency", i), 64'(done_at),
                  ((vtab[i].kind == 1) || (vtab[i].kind == 2 && vtab[i].we)) ? 64'd1 : 64'(LAT + 2));
        end

        // Simultaneous requests: VGA, NTSC, PROC on consecutive cycles
        drive_vga(10'd2, 10'd1, 19'h00201);
        drive_ntsc(18'h00010, 36'h111111111, 19'h40010);
        drive_proc(1'b0, 1'b0, 18'h00050, 36'd0, 19'h00050);
        tick;
        clear_flags;
        tick;
        check("simul_vga_addr", {44'd0, mem_we, mem_addr}, {44'd0, 1'b0, 19'h00201});
        tick;
        check("simul_ntsc_addr", {44'd0, mem_we, mem_addr}, {44'd0, 1'b1, 19'h40010});
        tick;
        check("simul_proc_addr", {44'd0, mem_we, mem_addr}, {44'd0, 1'b0, 19'h00050});
        tick;
        check("simul_ntsc_wdata", {28'd0, mem_wdata}, {28'd0, 36'h111111111});
        for (int k = 0; k < 6; k++) tick;

        // Overflow: second NTSC flag lost while VGA holds the memory
        for (int j = 0; j < 6; j++) begin
            drive_vga(10'd0, 10'd0, 19'h00000);
            if (j == 1) begin
                drive_ntsc(18'h00020, 36'h0AAAA5555, 19'h40020);
            end else if (j == 2) begin
                ntsc_flag = 1'b1; ntsc_addr = 18'h00021; ntsc_data = 36'h0BBBB6666;
            end else begin
                ntsc_flag = 1'b0;
            end
            tick;
        end
        clear_flags;
        tick;
        check("overflow_ntsc", {61'd0, overflow}, {61'd0, 3'b010});
        for (int k = 0; k < 8; k++) tick;

        // Bank swap with an NTSC write in flight and a second frame_flag
        drive_ntsc(18'h00030, 36'h0C0FFEE00, 19'h40030);
        tick;
        clear_flags;
        frame_flag = 1'b1;
        tick;
        clear_flags;
        check("swap_wait_e1", {63'd0, display_bank}, 64'd0);
        frame_flag = 1'b1;
        drive_ntsc(18'h00040, 36'h0FACE0040, 19'h00040);
        tick;
        clear_flags;
        check("swap_wait_e2", {63'd0, display_bank}, 64'd0);
        tick;
        check("swap_wait_e3", {62'd0, display_bank, mem_we}, 64'd0);
        tick;
        check("swap_wait_e4", {62'd0, display_bank, mem_we}, 64'd0);
        tick;
        check("swap_toggle_e5", {62'd0, display_bank, mem_we}, {62'd0, 2'b10});
        tick;
        check("swap_ntsc_new_bank", {44'd0, mem_we, mem_addr}, {44'd0, 1'b1, 19'h00040});
        for (int k = 0; k < 4; k++) tick;
        check("swap_single_toggle", {63'd0, display_bank}, 64'd1);
        drive_vga(10'd4, 10'd0, 19'h40002);
        tick;
        clear_flags;
        tick;
        check("vga_after_swap_addr", {45'd0, mem_addr}, {45'd0, 19'h40002});
        for (int k = 0; k < 8; k++) tick;

        // Everything issued must have completed
        check("vga_q_empty", 64'(vga_q.size()), 64'd0);
        check("proc_q_empty", 64'(proc_q.size()), 64'd0);
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        check("ntsc_done_count", 64'(ntsc_cnt), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/zbt_frame_arbiter.md
Name: zbt_frame_arbiter

Overview:
- Single-port arbiter and sequencer for the pipelined ZBT frame memory. The memory is 36-bit words, each holding two 18-bit YCrCb pixels.
- Arbitrates between three requesters:
  - VGA display reads: one pulse every 4 cycles, highest priority.
  - NTSC capture writes.
  - Processor read/write.
- Manages ping-pong frame banks so the VGA reader never scans the bank the NTSC writer is filling.
- Sits between the capture, processing and VGA write blocks and the external memory pins.

Parameters:
- ADDR_W, 19, memory word address width: 1 bank bit plus 18 offset bits.
- DATA_W, 36, memory word width.
- LAT, 2, cycles from the address cycle to the data cycle, for both read data return and write data drive. Legal values are 1 to 4.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 resets the block.
- frame_flag  in  1  one-cycle pulse from NTSC capture: the write bank is complete.
- vga_flag  in  1  one-cycle VGA read request.
- vga_hcount  in  10  VGA pixel column of the request.
- vga_vcount  in  10  VGA line of the request.
- vga_pixel  out  DATA_W  read data for VGA.
- done_vga  out  1  one-cycle pulse: vga_pixel is valid.
- ntsc_flag  in  1  one-cycle write request.
- ntsc_addr  in  18  word offset within the write bank.
- ntsc_data  in  DATA_W  write data.
- done_ntsc  out  1  write-accepted pulse.
- proc_flag  in  1  one-cycle request.
- proc_we  in  1  1 = write, 0 = read.
- proc_bank  in  1  bank to access.
- proc_addr  in  18  word offset.
- proc_wdata  in  DATA_W  write data.
- proc_rdata  out  DATA_W  read data.
- done_proc  out  1  completion pulse.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  write enable, active high, in the address cycle.
- mem_wdata  out  DATA_W  write data, driven LAT cycles after the address cycle.
- mem_rdata  in  DATA_W  read data, valid LAT cycles after the address cycle.
- display_bank  out  1  bank currently scanned by VGA. NTSC writes bank ~display_bank.
- overflow  out  3  sticky lost-request flags {proc, ntsc, vga}.

Behaviour:
- Reset (reset==0 at an edge): all of the following clear to 0 on that edge:
  - pending latches, latency pipeline, all done_* outputs, mem_we, mem_addr, mem_wdata;
  - vga_pixel, proc_rdata, display_bank, overflow, swap_pending.
  - Reset asserted mid-transaction discards all in-flight requests; no done pulse is produced for them.
- Request capture:
  - Each requester has a one-deep pending register holding the address, plus data and direction where applicable.
  - A flag sets pending and latches its inputs.
  - A flag arriving while that requester is still pending, and not being granted this cycle, is dropped, and the requester's overflow bit is set. Overflow bits clear only on reset.
  - A flag in the same cycle as a grant of that requester's pending entry is accepted: it refills the pending register.
- Grant:
  - At most one grant per cycle, fixed priority VGA > NTSC > PROC.
  - A request may be granted in the cycle after its flag at the earliest, so there is 1 cycle of capture latency.
  - Grant cycle outputs:
    - mem_addr is registered.
    - mem_we=1 for a write grant; mem_we=0 for a read grant or an idle cycle.
    - mem_addr holds its last value when idle.
- Address formation:
  - VGA: {display_bank, vga_vcount[8:0], vga_hcount[9:1]}.
  - NTSC: {~display_bank, ntsc_addr}, with the bank sampled at grant time.
  - PROC: {proc_bank, proc_addr}.
- Latency pipeline: a LAT-deep shift register of {valid, id[1:0], we, wdata} advances every cycle. At stage LAT:
  - Write entry: mem_wdata = the entry's data.
  - Read entry: the requester's data register captures mem_rdata, and its done pulses in the same cycle the data register updates. VGA read latency is therefore 1 + 1 + LAT cycles after vga_flag, i.e. 4 when LAT=2.
  - Write completion: done_ntsc, or done_proc for a write, pulses in the cycle after the grant.
  - Data outputs hold their value between done pulses.
- Bank swap:
  - frame_flag sets swap_pending.
  - While swap_pending=1, new NTSC grants are withheld; NTSC flags still latch.
  - display_bank toggles in the first cycle where swap_pending=1 and no NTSC write sits in the pipeline. swap_pending clears in that cycle.
  - A frame_flag that arrives while swap_pending=1 is absorbed: exactly one toggle results.
- Bandwidth: VGA uses at most 1 of every 4 cycles. NTSC and PROC must never starve VGA; they may wait indefinitely when both are saturated, with NTSC served ahead of PROC.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all flags pulsing -> all outputs 0, no done pulses; first request after release is granted the cycle after its flag.
- VGA read timing: display_bank=0, vga_flag with hcount=13, vcount=5 -> mem_addr=0x00A06 next cycle, mem_we=0; with mem_rdata=0x123456789 at grant+2, done_vga pulses 4 cycles after the flag and vga_pixel=0x123456789.
- Simultaneous requests: vga_flag, ntsc_flag (addr 0x00010) and proc_flag in one cycle -> grants on 3 consecutive cycles in order VGA, NTSC (addr 0x40010, mem_we=1, mem_wdata driven 2 cycles later), PROC.
- Overflow: two ntsc_flag pulses 1 cycle apart while VGA is granted continuously -> second flag dropped, overflow=3'b010, first write completes with its original data.
- Bank swap: NTSC write in flight when frame_flag pulses -> display_bank toggles 0->1 only after that write's stage-LAT cycle; a second frame_flag during the wait gives a single toggle; subsequent VGA addresses carry bit 18 = 1.
- Processor read: proc_flag with we=0, bank=1, addr 0x3FFFF -> mem_addr=0x7FFFF; done_proc pulses with proc_rdata equal to mem_rdata at stage LAT.
